shader_sequencer: RTL

//  Single-thread instruction sequencer for the mini shader core: fetches 32-bit instructions from

---
 rtl/shader_sequencer_if.sv | 67 ++++++
 rtl/shader_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/shader_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : shader_sequencer_if
//  Purpose  : Bus bundle between the shader sequencer and its neighbours
//             (instruction memory, register file, ALU, data memory).
//  Revision : 1.0  initial release
// ============================================================================
interface shader_sequencer_if #(
  parameter int NUM_REGS   = 16,
  parameter int MEM_DEPTH  = 256,
  parameter int IMEM_DEPTH = 256
);
  localparam int RIDX_W  = $clog2(NUM_REGS);
  localparam int DADDR_W = $clog2(MEM_DEPTH);
  localparam int PC_W    = $clog2(IMEM_DEPTH);

  // instruction memory
  logic               imem_rd_en;
  logic [PC_W-1:0]    imem_addr;
  logic [31:0]        imem_rdata;
  // register file
  logic [RIDX_W-1:0]  rf_rd_idx0;
  logic [RIDX_W-1:0]  rf_rd_idx1;
  logic [31:0]        rf_rd_data0;
  logic [31:0]        rf_rd_data1;
  logic               rf_wr_en;
  logic [RIDX_W-1:0]  rf_wr_idx;
  logic [31:0]        rf_wr_data;
  // ALU
  logic [4:0]         alu_opcode;
  logic [10:0]        alu_immd;
  logic [31:0]        alu_reg0;
  logic [31:0]        alu_reg1;
  logic               alu_wr_en;
  logic [31:0]        alu_wr_data;
  logic               alu_mem_wr_en;
  // data memory
  logic               dmem_rd_en;
  logic [DADDR_W-1:0] dmem_rd_addr;
  logic               dmem_wr_en;

  // sequencer side
  modport master (
    output imem_rd_en, imem_addr,
    input  imem_rdata,
    output rf_rd_idx0, rf_rd_idx1,
    input  rf_rd_data0, rf_rd_data1,
    output rf_wr_en, rf_wr_idx, rf_wr_data,
    output alu_opcode, alu_immd, alu_reg0, alu_reg1,
    input  alu_wr_en, alu_wr_data, alu_mem_wr_en,
    output dmem_rd_en, dmem_rd_addr, dmem_wr_en
  );

  // memories / register file / ALU side
  modport slave (
    input  imem_rd_en, imem_addr,
    output imem_rdata,
    input  rf_rd_idx0, rf_rd_idx1,
    output rf_rd_data0, rf_rd_data1,
    input  rf_wr_en, rf_wr_idx, rf_wr_data,
    input  alu_opcode, alu_immd, alu_reg0, alu_reg1,
    output alu_wr_en, alu_wr_data, alu_mem_wr_en,
    input  dmem_rd_en, dmem_rd_addr, dmem_wr_en
  );
endinterface
`default_nettype wire

// File: rtl/shader_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : shader_sequencer
//  Purpose  : Single-thread fetch/decode/execute sequencer for the mini shader
//             core. One instruction every three cycles; the ALU is purely
//             combinational and all commits happen in EXEC.
//  Revision : 1.0  initial release
// ============================================================================
module shader_sequencer #(
  parameter int NUM_REGS   = 16,
  parameter int MEM_DEPTH  = 256,
  parameter int IMEM_DEPTH = 256,
  localparam int PC_W      = $clog2(IMEM_DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          start_i,
  input  wire logic [PC_W:0] prog_len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [PC_W:0]      retired_o,
  shader_sequencer_if.master bus
);
  localparam int RIDX_W  = $clog2(NUM_REGS);
  localparam int DADDR_W = $clog2(MEM_DEPTH);

  // Only LOAD needs special handling here: its data-memory read is issued
  // in DECODE so the word is on the ALU's read port during EXEC.
  localparam logic [4:0] OP_LOAD = 5'h08;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W:0]     retired_q, retired_d;
  logic [PC_W:0]     len_q, len_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       reg0_q, reg0_d;
  logic [31:0]       reg1_q, reg1_d;

  // Source fields and reserved bits of the latched word are consumed in
  // DECODE straight from the memory data, so they are not read afterwards.
  logic w_unused_instr;
  assign w_unused_instr = &{1'b0, instr_q[22:11]};

  assign retired_o = retired_q;

  // State register and datapath latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      retired_q <= '0;
      len_q     <= '0;
      instr_q   <= '0;
      reg0_q    <= '0;
      reg1_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      len_q     <= len_d;
      instr_q   <= instr_d;
      reg0_q    <= reg0_d;
      reg1_q    <= reg1_d;
    end
  end

  // Next-state and output decode; every strobe is forced low while rst is high
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    len_d     = len_q;
    instr_d   = instr_q;
    reg0_d    = reg0_q;
    reg1_d    = reg1_q;

    busy_o             = 1'b0;
    done_o             = 1'b0;
    bus.imem_rd_en     = 1'b0;
    bus.imem_addr      = pc_q;
    bus.rf_rd_idx0     = '0;
    bus.rf_rd_idx1     = '0;
    bus.rf_wr_en       = 1'b0;
    bus.rf_wr_idx      = '0;
    bus.rf_wr_data     = '0;
    bus.alu_opcode     = '0;
    bus.alu_immd       = '0;
    bus.alu_reg0       = '0;
    bus.alu_reg1       = '0;
    bus.dmem_rd_en     = 1'b0;
    bus.dmem_rd_addr   = '0;
    bus.dmem_wr_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d     = prog_len_i;
          pc_d      = '0;
          retired_d = '0;
          state_d   = (prog_len_i == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        busy_o         = 1'b1;
        bus.imem_rd_en = 1'b1;
        state_d        = S_DECODE;
      end
      S_DECODE: begin
        busy_o         = 1'b1;
        instr_d        = bus.imem_rdata;
        bus.rf_rd_idx0 = bus.imem_rdata[19 +: RIDX_W];
        bus.rf_rd_idx1 = bus.imem_rdata[15 +: RIDX_W];
        reg0_d         = bus.rf_rd_data0;
        reg1_d         = bus.rf_rd_data1;
        if (bus.imem_rdata[31:27] == OP_LOAD) begin
          bus.dmem_rd_en   = 1'b1;
          bus.dmem_rd_addr = bus.imem_rdata[DADDR_W-1:0];
        end
        state_d = S_EXEC;
      end
      S_EXEC: begin
        busy_o         = 1'b1;
        bus.alu_opcode = instr_q[31:27];
        bus.alu_immd   = instr_q[10:0];
        bus.alu_reg0   = reg0_q;
        bus.alu_reg1   = reg1_q;
        bus.rf_wr_en   = bus.alu_wr_en;
        bus.rf_wr_idx  = instr_q[23 +: RIDX_W];
        bus.rf_wr_data = bus.alu_wr_data;
        bus.dmem_wr_en = bus.alu_mem_wr_en;
        retired_d      = retired_q + 1'b1;
        pc_d           = pc_q + 1'b1;   // wraps modulo IMEM_DEPTH
        state_d        = ((retired_q + 1'b1) == len_q) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      busy_o         = 1'b0;
      done_o         = 1'b0;
      bus.imem_rd_en = 1'b0;
      bus.rf_wr_en   = 1'b0;
      bus.dmem_rd_en = 1'b0;
      bus.dmem_wr_en = 1'b0;
      bus.alu_opcode = '0;
      bus.alu_immd   = '0;
      bus.alu_reg0   = '0;
      bus.alu_reg1   = '0;
    end
  end
endmodule
`default_nettype wire
